contrast_lut_stream: RTL and testbench
======================================

# contrast_lut_stream

Parametrised successor to the contrast LUT/contrast pair in the video-enhancement pipe. It builds a 2^PIX_W-entry contrast table in hardware from a fixed-point gain, then applies it to a CH-channel pixel stream with fixed two-cycle latency. While the table is being rebuilt, pixels pass through unmodified. Out-of-range gains are rejected, and the previous table is kept.

## Interface
- PIX_W, default 8: bits per colour channel. The table has 2^PIX_W entries of PIX_W bits.
- CH, default 3: number of channels packed in a pixel. All channels share one table through CH read ports.
- FP_W, default 8: width of the unsigned contrast gain.
- FRAC, default 4: fractional bits of the gain (0x10 = 1.0).
- MAX_FP, default 8'h40: largest legal gain (4.0).
- clk, in, 1: clock, rising edge.
- resetN, in, 1: reset, asynchronous, active-low.
- en_cp, in, 1: enable contrast processing. 0 = bypass.
- contrast_fp, in, FP_W: gain, sampled only on an accepted start.
- start, in, 1: single-cycle request to rebuild the table.
- busy, out, 1: table build in progress.
- tbl_valid, out, 1: table holds a successfully built gain.
- invalid, out, 1: last start was rejected.
- pix_valid_in, in, 1: input pixel qualifier. No back-pressure.
- pix_in, in, CH*PIX_W: channel 0 is in the LSBs.
- pix_valid_out, out, 1: output pixel qualifier.
- pix_out, out, CH*PIX_W: processed pixel.
- sat_cnt, out, 32: clipped-pixel count. Present only with CONTRAST_SAT_CNT_EN; otherwise tied to 0.

## Operation
- FSM states: IDLE, BUILD.
- IDLE → BUILD on start=1 when 0 < contrast_fp ≤ MAX_FP.
  - Latches the gain and clears the build address and invalid.
  - Sets busy; clears tbl_valid.
- start with contrast_fp = 0 or > MAX_FP:
  - Sets invalid=1 and stays in IDLE.
  - Table and tbl_valid are unchanged.
- start while in BUILD is ignored, with no effect on invalid.
- BUILD writes one entry per cycle at addr 0 .. 2^PIX_W−1:
  - d = addr − 2^(PIX_W−1), signed, PIX_W+1 bits.
  - p = d × gain, signed, full width.
  - y = (p >>> FRAC) + 2^(PIX_W−1), using an arithmetic (floor) shift.
  - Clamp y to [0, 2^PIX_W−1] and store a clip flag alongside the entry.
- After the last address: BUILD → IDLE, busy=0, tbl_valid=1.
- Pixel mode is decided per pixel at input stage 1:
  - Apply the table when en_cp && tbl_valid && !busy.
  - Otherwise pass the pixel through unchanged.
- Each channel is looked up independently in the shared table.

## Timing
- Reset values: busy=0, tbl_valid=0, invalid=0, pix_valid_out=0, pix_out=0, sat_cnt=0, FSM=IDLE. Table contents are don't-care.
- Reset asserted mid-BUILD aborts the build; tbl_valid stays 0 until the next complete build.
- busy rises the cycle after an accepted start and stays high for exactly 2^PIX_W cycles (256 at default).
- Latency is 2 cycles from pix_valid_in/pix_in to pix_valid_out/pix_out, in every mode.
  - Stage 1 registers the pixel and mode.
  - Stage 2 registers the table read or the bypass value.
- pix_valid_out is the input valid delayed by 2 cycles. pix_out holds its value when the output is not valid.
- Mode is sampled per pixel, so a pixel accepted the cycle before busy rises still uses the old table.
- Back-to-back pixels are accepted at 1 per cycle.

## Configuration
- CONTRAST_SAT_CNT_EN defined:
  - sat_cnt increments by 1 for each valid output pixel with any channel's clip flag set in table mode.
  - Saturates at 2^32−1.
  - Cleared on an accepted start.
- CONTRAST_SAT_CNT_EN undefined: no clip-flag storage; sat_cnt is constant 0.

## Test plan
- Identity gain: start with gain 0x10, wait 256 cycles, en_cp=1, pixel 0x37_37_37 → 0x37_37_37 two cycles later, tbl_valid=1.
- Gain 0x20:
  - 0x70 → 0x60.
  - 0xC0 → 0xFF (clamped).
  - 0x00 → 0x00 (clamped).
- Gain 0x08: 0x00 → 0x40, and 0xFF → 0xBF.
- Rejected gain: start with gain 0x00, then start with gain 0x41 → invalid=1 after each, busy stays 0, and the previous gain-0x20 output is unchanged.
- Bypass during build:
  - Stream pixels while busy=1 → pix_out equals pix_in delayed by 2.
  - A second start mid-build is ignored; busy stays high exactly 256 cycles.
  - Reset mid-build → tbl_valid=0.
- With CONTRAST_SAT_CNT_EN, gain 0x20, pixels 0x00, 0xFF, 0x80, 0x90 (all channels equal):
  - Outputs are 0x00, 0xFF, 0x80, 0xA0.
  - sat_cnt=2.

Source files
------------

// File: rtl/contrast_lut_stream.sv
// Contrast LUT builder plus CH-channel pixel stream with fixed two-cycle latency.
// Optional clipped-pixel counter is compiled in with CONTRAST_SAT_CNT_EN.
module contrast_lut_stream #(
  parameter int unsigned     PIX_W  = 8,
  parameter int unsigned     CH     = 3,
  parameter int unsigned     FP_W   = 8,
  parameter int unsigned     FRAC   = 4,
  parameter logic [FP_W-1:0] MAX_FP = 8'h40
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                en_cp,
  input  logic [FP_W-1:0]     contrast_fp,
  input  logic                start,
  output logic                busy,
  output logic                tbl_valid,
  output logic                invalid,
  input  logic                pix_valid_in,
  input  logic [CH*PIX_W-1:0] pix_in,
  output logic                pix_valid_out,
  output logic [CH*PIX_W-1:0] pix_out,
  output logic [31:0]         sat_cnt
);

  localparam int unsigned           DEPTH = 1 << PIX_W;
  localparam int unsigned           PW    = PIX_W + FP_W + 2;
  localparam logic signed [PW-1:0]  HALF  = PW'(DEPTH / 2);
  localparam logic signed [PW-1:0]  TOP   = PW'(DEPTH - 1);
  localparam logic [PIX_W-1:0]      LAST  = PIX_W'(DEPTH - 1);

  typedef enum logic {IDLE, BUILD} state_e;

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   addr_q, addr_d;
  logic [FP_W-1:0]    gain_q, gain_d;
  logic               busy_q, busy_d;
  logic               tbl_valid_q, tbl_valid_d;
  logic               invalid_q, invalid_d;
  logic               wr_en;
  logic               gain_ok;

  logic signed [PW-1:0] d_w, g_w, p_w, y_w;
  logic [PIX_W:0]       entry;

  logic [PIX_W-1:0]   lut [DEPTH];

  logic                vld_p1_q, mode_p1_q;
  logic [CH*PIX_W-1:0] pix_p1_q;
  logic [CH*PIX_W-1:0] pix_tbl;
  logic                clip_any;
  logic                pix_valid_out_q;
  logic [CH*PIX_W-1:0] pix_out_q;

  // Clamp to the pixel range; MSB of the result flags a clipped entry.
  function automatic logic [PIX_W:0] clamp_pix(input logic signed [PW-1:0] y);
    if (y[PW-1])
      return {1'b1, {PIX_W{1'b0}}};
    else if (y > TOP)
      return {1'b1, {PIX_W{1'b1}}};
    else
      return {1'b0, y[PIX_W-1:0]};
  endfunction

  assign gain_ok = (contrast_fp != '0) && (contrast_fp <= MAX_FP);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    gain_d      = gain_q;
    busy_d      = busy_q;
    tbl_valid_d = tbl_valid_q;
    invalid_d   = invalid_q;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (gain_ok) begin
            state_d     = BUILD;
            gain_d      = contrast_fp;
            addr_d      = '0;
            invalid_d   = 1'b0;
            busy_d      = 1'b1;
            tbl_valid_d = 1'b0;
          end else begin
            invalid_d = 1'b1;
          end
        end
      end
      BUILD: begin
        wr_en  = 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          tbl_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      gain_q      <= '0;
      busy_q      <= 1'b0;
      tbl_valid_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      gain_q      <= gain_d;
      busy_q      <= busy_d;
      tbl_valid_q <= tbl_valid_d;
      invalid_q   <= invalid_d;
    end
  end

  // Entry value: centre the code, scale by the gain, floor-shift, re-centre.
  always_comb begin
    d_w   = $signed(PW'(addr_q)) - HALF;
    g_w   = $signed(PW'(gain_q));
    p_w   = d_w * g_w;
    y_w   = (p_w >>> FRAC) + HALF;
    entry = clamp_pix(y_w);
  end

  always_ff @(posedge clk) begin
    if (wr_en) lut[addr_q] <= entry[PIX_W-1:0];
  end

`ifdef CONTRAST_SAT_CNT_EN
  logic        clip_mem [DEPTH];
  logic        sat_clr;
  logic [31:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (wr_en) clip_mem[addr_q] <= entry[PIX_W];
  end

  assign sat_clr = (state_q == IDLE) && start && gain_ok;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      sat_cnt_q <= '0;
    else if (sat_clr)
      sat_cnt_q <= '0;
    else if (vld_p1_q && mode_p1_q && clip_any && (sat_cnt_q != '1))
      sat_cnt_q <= sat_cnt_q + 32'd1;
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic clip_unused;
  assign clip_unused = entry[PIX_W];
  assign sat_cnt     = '0;
`endif

  // Stage 1: register pixel and decide table vs bypass for this pixel.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vld_p1_q  <= 1'b0;
      mode_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= pix_valid_in;
      mode_p1_q <= en_cp && tbl_valid_q && !busy_q;
    end
  end

  always_ff @(posedge clk) begin
    pix_p1_q <= pix_in;
  end

  always_comb begin
    pix_tbl  = '0;
    clip_any = 1'b0;
    for (int c = 0; c < CH; c++) begin
      pix_tbl[c*PIX_W +: PIX_W] = lut[pix_p1_q[c*PIX_W +: PIX_W]];
`ifdef CONTRAST_SAT_CNT_EN
      clip_any = clip_any | clip_mem[pix_p1_q[c*PIX_W +: PIX_W]];
`endif
    end
  end

  // Stage 2: register table read or bypass value; hold when not valid.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pix_valid_out_q <= 1'b0;
      pix_out_q       <= '0;
    end else begin
      pix_valid_out_q <= vld_p1_q;
      if (vld_p1_q) pix_out_q <= mode_p1_q ? pix_tbl : pix_p1_q;
    end
  end

  assign busy          = busy_q;
  assign tbl_valid     = tbl_valid_q;
  assign invalid       = invalid_q;
  assign pix_valid_out = pix_valid_out_q;
  assign pix_out       = pix_out_q;

endmodule

// File: tb/tb_contrast_lut_stream.sv
// Directed self-checking bench for contrast_lut_stream (default parameters).
module tb_contrast_lut_stream;

  logic        clk = 1'b0;
  logic        resetN;
  logic        en_cp;
  logic [7:0]  contrast_fp;
  logic        start;
  logic        busy;
  logic        tbl_valid;
  logic        invalid;
  logic        pix_valid_in;
  logic [23:0] pix_in;
  logic        pix_valid_out;
  logic [23:0] pix_out;
  logic [31:0] sat_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  logic [23:0] stream_v [4];

  contrast_lut_stream dut (
    .clk          (clk),
    .resetN       (resetN),
    .en_cp        (en_cp),
    .contrast_fp  (contrast_fp),
    .start        (start),
    .busy         (busy),
    .tbl_valid    (tbl_valid),
    .invalid      (invalid),
    .pix_valid_in (pix_valid_in),
    .pix_in       (pix_in),
    .pix_valid_out(pix_valid_out),
    .pix_out      (pix_out),
    .sat_cnt      (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] g);
    contrast_fp = g;
    start       = 1'b1;
    step();
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_build(input string tag);
    while (busy && (cyc - t0) < 1000) step();
    chk({tag, "_busy_len"}, cyc - t0, 256);
    chk({tag, "_tbl_valid"}, {31'd0, tbl_valid}, 1);
  endtask

  task automatic send_pix(input string tag, input logic [23:0] p, input logic [23:0] exp);
    pix_in       = p;
    pix_valid_in = 1'b1;
    step();
    pix_valid_in = 1'b0;
    step();
    chk({tag, "_vld"}, {31'd0, pix_valid_out}, 1);
    chk(tag, {8'd0, pix_out}, {8'd0, exp});
  endtask

  initial begin
    resetN       = 1'b0;
    en_cp        = 1'b0;
    contrast_fp  = '0;
    start        = 1'b0;
    pix_valid_in = 1'b0;
    pix_in       = '0;
    repeat (3) step();

    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_tbl_valid", {31'd0, tbl_valid}, 0);
    chk("rst_invalid", {31'd0, invalid}, 0);
    chk("rst_pvo", {31'd0, pix_valid_out}, 0);
    chk("rst_pix_out", {8'd0, pix_out}, 0);
    chk("rst_sat", sat_cnt, 0);
    resetN = 1'b1;
    step();

    // Identity gain
    do_start(8'h10);
    chk("g10_busy_rise", {31'd0, busy}, 1);
    wait_build("g10");
    en_cp = 1'b1;
    send_pix("g10_37", 24'h373737, 24'h373737);

    // Gain 2.0
    do_start(8'h20);
    wait_build("g20");
    send_pix("g20_70", 24'h707070, 24'h606060);
    send_pix("g20_c0", 24'hC0C0C0, 24'hFFFFFF);
    send_pix("g20_00", 24'h000000, 24'h000000);

    // Rejected gains keep the old table
    do_start(8'h00);
    chk("rej0_invalid", {31'd0, invalid}, 1);
    chk("rej0_busy", {31'd0, busy}, 0);
    step();
    do_start(8'h41);
    chk("rej41_invalid", {31'd0, invalid}, 1);
    chk("rej41_busy", {31'd0, busy}, 0);
    chk("rej41_tbl_valid", {31'd0, tbl_valid}, 1);
    send_pix("rej_70", 24'h707070, 24'h606060);

    // Gain 0.5, also clears invalid
    do_start(8'h08);
    chk("g08_invalid_clr", {31'd0, invalid}, 0);
    wait_build("g08");
    send_pix("g08_00", 24'h000000, 24'h404040);
    send_pix("g08_ff", 24'hFFFFFF, 24'hBFBFBF);
    send_pix("g08_mix", 24'h00FF80, 24'h40BF80);

    en_cp = 1'b0;
    send_pix("bypass_en0", 24'h123456, 24'h123456);
    en_cp = 1'b1;

    // Pixel in the start cycle still uses the gain-0.5 table
    contrast_fp  = 8'h20;
    start        = 1'b1;
    pix_in       = 24'h000000;
    pix_valid_in = 1'b1;
    step();
    t0           = cyc;
    start        = 1'b0;
    pix_valid_in = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 1);
    step();
    chk("oldtbl_vld", {31'd0, pix_valid_out}, 1);
    chk("oldtbl_pix", {8'd0, pix_out}, 32'h00404040);

    // Back-to-back bypass stream while building, with ignored starts
    stream_v[0] = 24'h707070;
    stream_v[1] = 24'hC01234;
    stream_v[2] = 24'h00FF80;
    stream_v[3] = 24'hA5A5A5;
    for (int i = 0; i < 4; i++) begin
      pix_in       = stream_v[i];
      pix_valid_in = 1'b1;
      start        = (i == 1) || (i == 2);
      contrast_fp  = (i == 1) ? 8'h10 : 8'h00;
      step();
      if (i >= 1) begin
        chk("bld_vld", {31'd0, pix_valid_out}, 1);
        chk("bld_pix", {8'd0, pix_out}, {8'd0, stream_v[i-1]});
      end
    end
    start        = 1'b0;
    pix_valid_in = 1'b0;
    step();
    chk("bld_last", {8'd0, pix_out}, {8'd0, stream_v[3]});
    step();
    chk("bld_idle_vld", {31'd0, pix_valid_out}, 0);
    chk("bld_hold", {8'd0, pix_out}, {8'd0, stream_v[3]});
    chk("bld_invalid", {31'd0, invalid}, 0);
    wait_build("g20b");
    send_pix("g20b_70", 24'h707070, 24'h606060);

    // Clip counter
    send_pix("sat_00", 24'h000000, 24'h000000);
    send_pix("sat_ff", 24'hFFFFFF, 24'hFFFFFF);
    send_pix("sat_80", 24'h808080, 24'h808080);
    send_pix("sat_90", 24'h909090, 24'hA0A0A0);
`ifdef CONTRAST_SAT_CNT_EN
    chk("sat_cnt", sat_cnt, 2);
`else
    chk("sat_cnt_off", sat_cnt, 0);
`endif

    // Reset mid-build aborts it
    do_start(8'h10);
    repeat (10) step();
    resetN = 1'b0;
    #2;
    chk("midrst_tbl_valid", {31'd0, tbl_valid}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    step();
    resetN = 1'b1;
    step();
    chk("midrst_tbl_valid2", {31'd0, tbl_valid}, 0);
    send_pix("midrst_bypass", 24'h707070, 24'h707070);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
